cache_mem_ctrl: RTL and testbench
=================================

CACHE_MEM_CTRL -- requirements
Module: cache_mem_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 rst  in  1  reset, asynchronous and active-high.
REQ-003 ic_req  in  1  instruction-cache line-miss request (cache mem_req).
REQ-004 ic_addr  in  23  instruction-cache tag_index_mem word address; bits [2:0] are ignored.
REQ-005 dc_req  in  1  data-cache line-miss request.
REQ-006 dc_addr  in  23  data-cache tag_index_mem word address; bits [2:0] are ignored.
REQ-007 sb_req  in  1  store-buffer write-through request.
REQ-008 sb_addr  in  23  store word address.
REQ-009 sb_data  in  32  store data.
REQ-010 sb_ack  out  1  one-cycle pulse when the store word has been accepted by memory.
REQ-011 mem_rd  out  1  memory word-read strobe, held until mem_ready.
REQ-012 mem_wr  out  1  memory word-write strobe, held until mem_ready.
REQ-013 mem_addr  out  23  memory word address.
REQ-014 mem_wdata  out  32  write data.
REQ-015 mem_rdata  in  32  read data, valid when mem_ready=1 during mem_rd.
REQ-016 mem_ready  in  1  memory completes the current word access this cycle.
REQ-017 line_out  out  256  assembled line to both caches (cache line_in).
REQ-018 ic_we_mem  out  1  one-cycle fill strobe to the instruction cache.
REQ-019 dc_we_mem  out  1  one-cycle fill strobe to the data cache.

Function
REQ-020 FSM states: IDLE, READ, FILL, WRITE.
REQ-021 IDLE: when any request is pending, the block shall grant exactly one request, latch its address (and sb_data for a store) into internal registers, and move to READ (ic/dc) or WRITE (sb) on the next edge.
REQ-022 Arbitration: 3-way round-robin in the order ic -> dc -> sb -> ic, starting after the last granted requester; the last-granted pointer resets to sb, so ic has first priority after reset.
REQ-023 Hazard override: if dc_req=1, sb_req=1 and dc_addr[22:3]==sb_addr[22:3], the block shall grant sb first, regardless of the round-robin pointer.
REQ-024 READ: mem_rd=1 and mem_addr={latched_addr[22:3], beat}; beat is a 3-bit counter starting at 0.
REQ-025 On each READ cycle with mem_ready=1: capture mem_rdata into line_out[32*beat+31:32*beat] and increment beat; at beat 7 the block shall go to FILL instead of incrementing.
REQ-026 A read therefore takes 8 mem_ready beats, not necessarily consecutive; mem_ready=0 cycles stall with address and strobe held.
REQ-027 FILL: exactly one cycle with ic_we_mem=1 or dc_we_mem=1 (the granted requester only); next state IDLE.
REQ-028 line_out shall be stable during FILL and shall hold its value until the next READ beat overwrites it.
REQ-029 WRITE: mem_wr=1, mem_addr=latched sb_addr, mem_wdata=latched sb_data; on mem_ready=1 the block shall pulse sb_ack for that same cycle and go to IDLE.
REQ-030 mem_rd and mem_wr shall never be 1 together; outside READ/WRITE both shall be 0.
REQ-031 Requests are sampled only in IDLE; requester address changes after grant have no effect.
REQ-032 Minimum gap between a fill strobe and the next grant is 1 IDLE cycle. This is compatible with the caches masking mem_req during we_mem and the cycle after it.
REQ-033 ic_we_mem, dc_we_mem and sb_ack shall be mutually exclusive.

Reset
REQ-034 On rst: state=IDLE, beat=0, rr pointer=sb, and outputs mem_rd=mem_wr=sb_ack=ic_we_mem=dc_we_mem=0, mem_addr=0, mem_wdata=0, line_out=0.
REQ-035 Reset mid-READ or mid-WRITE shall abort the access with no fill strobe or ack; the requester shall re-request afterwards.

Verification
REQ-036 Single dc miss: dc_addr=0x000128, mem_ready always 1, word k=0xA0+k -> mem_addr 0x000128..0x00012F; dc_we_mem pulses at cycle 10 after the request; line_out[31:0]=0xA0 and line_out[255:224]=0xA7.
REQ-037 Simultaneous ic_req and dc_req after reset -> ic is served first, then dc; exactly one ic_we_mem pulse and one dc_we_mem pulse, in that order.
REQ-038 Hazard: dc_addr=0x000040, sb_addr=0x000045, sb_data=0xDEADBEEF, pointer favouring dc -> the WRITE completes (sb_ack) before the first mem_rd.
REQ-039 Stall: mem_ready toggles 1,0,0,1,... during READ -> mem_addr and mem_rd are held across the 0 cycles; the line is correct; the fill arrives after 8 ready beats.
REQ-040 rst asserted at beat 4 of a read -> all outputs 0 immediately and no we pulse; the re-issued request then completes a full 8-beat fill.
REQ-041 ic, dc and sb requesting continuously -> grant order cycles ic, dc, sb, ic, ...; no requester waits for more than 2 other transactions.

Source files
------------

// File: rtl/cache_mem_ctrl.sv
// Line-fill / write-through memory controller shared by the I-cache, D-cache and store buffer.
// One requester is served at a time: 8-beat line reads for cache misses, single-word store writes.
module cache_mem_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         ic_req,
  input  logic [22:0]  ic_addr,
  input  logic         dc_req,
  input  logic [22:0]  dc_addr,
  input  logic         sb_req,
  input  logic [22:0]  sb_addr,
  input  logic [31:0]  sb_data,
  output logic         sb_ack,
  output logic         mem_rd,
  output logic         mem_wr,
  output logic [22:0]  mem_addr,
  output logic [31:0]  mem_wdata,
  input  logic [31:0]  mem_rdata,
  input  logic         mem_ready,
  output logic [255:0] line_out,
  output logic         ic_we_mem,
  output logic         dc_we_mem
);

  typedef enum logic [1:0] {IDLE, READ, FILL, WRITE} state_t;
  typedef enum logic [1:0] {SRC_IC, SRC_DC, SRC_SB} src_t;

  state_t      state, state_nxt;
  src_t        last, gnt, pick;
  logic [22:0] addr_q;
  logic [31:0] data_q;
  logic [2:0]  beat;
  logic        any_req, hazard;

  assign any_req = ic_req | dc_req | sb_req;
  // A store to the line being missed must reach memory before the line is read back.
  assign hazard  = dc_req && sb_req && (dc_addr[22:3] == sb_addr[22:3]);

  // Round-robin: search starts just after the last granted requester.
  always_comb begin
    pick = last;
    case (last)
      SRC_IC: begin
        if (dc_req)      pick = SRC_DC;
        else if (sb_req) pick = SRC_SB;
        else if (ic_req) pick = SRC_IC;
      end
      SRC_DC: begin
        if (sb_req)      pick = SRC_SB;
        else if (ic_req) pick = SRC_IC;
        else if (dc_req) pick = SRC_DC;
      end
      default: begin
        if (ic_req)      pick = SRC_IC;
        else if (dc_req) pick = SRC_DC;
        else if (sb_req) pick = SRC_SB;
      end
    endcase
    if (hazard) pick = SRC_SB;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (pick == SRC_SB) state_nxt = WRITE;
          else                state_nxt = READ;
        end
      end
      READ:    if (mem_ready && beat == 3'd7) state_nxt = FILL;
      FILL:    state_nxt = IDLE;
      WRITE:   if (mem_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign mem_rd    = (state == READ);
  assign mem_wr    = (state == WRITE);
  assign mem_addr  = mem_rd ? {addr_q[22:3], beat} : (mem_wr ? addr_q : 23'd0);
  assign mem_wdata = mem_wr ? data_q : 32'd0;
  assign sb_ack    = mem_wr & mem_ready;
  assign ic_we_mem = (state == FILL) && (gnt == SRC_IC);
  assign dc_we_mem = (state == FILL) && (gnt == SRC_DC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last     <= SRC_SB;
      gnt      <= SRC_SB;
      addr_q   <= '0;
      data_q   <= '0;
      beat     <= '0;
      line_out <= '0;
    end else begin
      if (state == IDLE && any_req) begin
        last <= pick;
        gnt  <= pick;
        beat <= '0;
        case (pick)
          SRC_IC:  addr_q <= ic_addr;
          SRC_DC:  addr_q <= dc_addr;
          default: begin
            addr_q <= sb_addr;
            data_q <= sb_data;
          end
        endcase
      end
      // beat wraps to 0 on the eighth word, ready for the next line.
      if (state == READ && mem_ready) begin
        line_out[{beat, 5'b0} +: 32] <= mem_rdata;
        beat <= beat + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_ctrl.sv
// Randomized bench for cache_mem_ctrl: behavioural memory, requester drivers and a
// round-robin/hazard reference model computed from the arbitration rules.
module tb_cache_mem_ctrl;

  logic         clk = 1'b0, rst;
  logic         ic_req, dc_req, sb_req;
  logic [22:0]  ic_addr, dc_addr, sb_addr;
  logic [31:0]  sb_data;
  logic         sb_ack, mem_rd, mem_wr;
  logic [22:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         mem_ready;
  logic [255:0] line_out;
  logic         ic_we_mem, dc_we_mem;

  cache_mem_ctrl dut (
    .clk(clk), .rst(rst),
    .ic_req(ic_req), .ic_addr(ic_addr),
    .dc_req(dc_req), .dc_addr(dc_addr),
    .sb_req(sb_req), .sb_addr(sb_addr), .sb_data(sb_data), .sb_ack(sb_ack),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .line_out(line_out), .ic_we_mem(ic_we_mem), .dc_we_mem(dc_we_mem)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int ready_mode = 0, pat_mode = 0, tog = 0;
  int rd_beats = 0, viol = 0, ic_pulses = 0, dc_pulses = 0;
  logic        prev_stall = 1'b0;
  logic [22:0] prev_addr = '0;
  logic [22:0] rd_addr_q[$], wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          done_id[$], done_cyc[$], done_rd[$];
  logic [22:0] done_addr[$];
  logic [31:0] done_data[$];
  logic [255:0] done_line[$];

  // Memory contents: fixed function of the word address.
  function automatic logic [31:0] mem_word(input logic [22:0] a);
    if (pat_mode == 0) return 32'hA0 + 32'(a[2:0]);
    return (32'(a) * 32'h9E3779B1) ^ 32'hC3A50F1E;
  endfunction

  function automatic logic [255:0] exp_line(input logic [22:0] a);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = mem_word({a[22:3], 3'(k)});
    return l;
  endfunction

  // 0=ic 1=dc 2=sb; next pending requester after 'last' in cyclic order.
  function automatic int rr_pick(input int last, input logic [2:0] pend, input bit hz);
    if (hz) return 2;
    for (int k = 1; k <= 3; k++) if (pend[(last + k) % 3]) return (last + k) % 3;
    return -1;
  endfunction

  // Memory responder: updates just after the rising edge.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (mem_rd || mem_wr) begin
        case (ready_mode)
          0:       mem_ready = 1'b1;
          1:       mem_ready = 1'($urandom_range(0, 1));
          default: mem_ready = (tog % 3 == 0);
        endcase
        tog++;
      end else begin
        mem_ready = 1'b0;
        tog = 0;
      end
      mem_rdata = mem_rd ? mem_word(mem_addr) : 32'h0;
    end
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_rd && mem_wr) viol++;
    if (int'(ic_we_mem) + int'(dc_we_mem) + int'(sb_ack) > 1) viol++;
    if (!rst && prev_stall && !(mem_rd && mem_addr == prev_addr)) viol++;
    prev_stall = !rst && mem_rd && !mem_ready;
    prev_addr  = mem_addr;
    if (mem_rd && mem_ready) begin
      rd_beats++;
      rd_addr_q.push_back(mem_addr);
    end
    if (mem_wr && mem_ready) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wdata);
    end
    if (ic_we_mem) ic_pulses++;
    if (dc_we_mem) dc_pulses++;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1;
    ic_req = 0; dc_req = 0; sb_req = 0;
    ic_addr = '0; dc_addr = '0; sb_addr = '0; sb_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise one requester's line and hold it until its completion pulse, then
  // keep it low through the following cycle (cache-side masking).
  task automatic run_req(input int id, input logic [22:0] a, input logic [31:0] d);
    bit got = 0;
    int n;
    @(negedge clk);
    case (id)
      0:       begin ic_addr = a; ic_req = 1'b1; end
      1:       begin dc_addr = a; dc_req = 1'b1; end
      default: begin sb_addr = a; sb_data = d; sb_req = 1'b1; end
    endcase
    for (n = 0; n < 2000; n++) begin
      @(negedge clk);
      if ((id == 0 && ic_we_mem) || (id == 1 && dc_we_mem) || (id == 2 && sb_ack)) begin
        got = 1;
        break;
      end
    end
    if (got) begin
      done_id.push_back(id);
      done_addr.push_back(a);
      done_data.push_back(d);
      done_line.push_back(line_out);
      done_cyc.push_back(n + 2);
      done_rd.push_back(rd_beats);
    end
    case (id)
      0:       ic_req = 1'b0;
      1:       dc_req = 1'b0;
      default: sb_req = 1'b0;
    endcase
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL req_timeout requester=%0d got no completion, want one within 2000 cycles", id);
    end
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if ({mem_rd, mem_wr, sb_ack, ic_we_mem, dc_we_mem} !== 5'b0) begin
      errors++;
      $display("FAIL reset_strobes got %b want 00000", {mem_rd, mem_wr, sb_ack, ic_we_mem, dc_we_mem});
    end
    checks++;
    if (mem_addr !== 23'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", mem_addr, mem_wdata);
    end
    checks++;
    if (line_out !== 256'h0) begin
      errors++;
      $display("FAIL reset_line got %h want 0", line_out);
    end
  endtask

  task automatic test_single_dc;
    int b, p_ic, p_dc, r0;
    do_reset();
    pat_mode = 0; ready_mode = 0;
    b = done_id.size(); p_ic = ic_pulses; p_dc = dc_pulses; r0 = rd_addr_q.size();
    run_req(1, 23'h000128, 32'h0);
    if (done_id.size() == b + 1) begin
      checks++;
      if (done_cyc[b] != 10) begin
        errors++;
        $display("FAIL dc_fill_cycle got %0d want 10", done_cyc[b]);
      end
      checks++;
      if (done_line[b][31:0] !== 32'hA0 || done_line[b][255:224] !== 32'hA7) begin
        errors++;
        $display("FAIL dc_line_ends got %h/%h want a0/a7", done_line[b][31:0], done_line[b][255:224]);
      end
      checks++;
      if (done_line[b] !== exp_line(23'h000128)) begin
        errors++;
        $display("FAIL dc_line got %h want %h", done_line[b], exp_line(23'h000128));
      end
    end
    checks++;
    if (rd_addr_q.size() != r0 + 8) begin
      errors++;
      $display("FAIL dc_beats got %0d want 8", rd_addr_q.size() - r0);
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (rd_addr_q[r0 + k] !== 23'h000128 + 23'(k)) begin
          errors++;
          $display("FAIL dc_addr_seq beat=%0d got %h want %h", k, rd_addr_q[r0 + k], 23'h000128 + 23'(k));
        end
      end
    end
    checks++;
    if (dc_pulses - p_dc != 1 || ic_pulses != p_ic) begin
      errors++;
      $display("FAIL dc_strobes got dc=%0d ic=%0d want 1/0", dc_pulses - p_dc, ic_pulses - p_ic);
    end
  endtask

  task automatic test_ic_dc_simultaneous;
    int b, p_ic, p_dc;
    logic [22:0] a_ic, a_dc;
    do_reset();
    pat_mode = 1; ready_mode = 1;
    a_ic = 23'($urandom); a_dc = 23'($urandom);
    b = done_id.size(); p_ic = ic_pulses; p_dc = dc_pulses;
    fork
      run_req(0, a_ic, 32'h0);
      run_req(1, a_dc, 32'h0);
    join
    checks++;
    if (done_id.size() != b + 2) begin
      errors++;
      $display("FAIL icdc_count got %0d want 2", done_id.size() - b);
    end else begin
      checks++;
      if (done_id[b] != rr_pick(2, 3'b011, 1'b0) || done_id[b + 1] != 1) begin
        errors++;
        $display("FAIL icdc_order got %0d,%0d want 0,1", done_id[b], done_id[b + 1]);
      end
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (done_line[b + k] !== exp_line(done_addr[b + k])) begin
          errors++;
          $display("FAIL icdc_line idx=%0d got %h want %h", k, done_line[b + k], exp_line(done_addr[b + k]));
        end
      end
    end
    checks++;
    if (ic_pulses - p_ic != 1 || dc_pulses - p_dc != 1) begin
      errors++;
      $display("FAIL icdc_strobes got ic=%0d dc=%0d want 1/1", ic_pulses - p_ic, dc_pulses - p_dc);
    end
  endtask

  task automatic test_hazard;
    int b, r0, exp_first;
    logic [22:0] a_dc, a_sb;
    do_reset();
    pat_mode = 1; ready_mode = 1;
    run_req(0, 23'($urandom), 32'h0);   // pointer now favours dc
    a_dc = 23'h000040; a_sb = 23'h000045;
    exp_first = rr_pick(0, 3'b110, a_dc[22:3] == a_sb[22:3]);
    r0 = rd_beats; b = done_id.size();
    fork
      run_req(1, a_dc, 32'h0);
      run_req(2, a_sb, 32'hDEADBEEF);
    join
    checks++;
    if (done_id.size() != b + 2) begin
      errors++;
      $display("FAIL hazard_count got %0d want 2", done_id.size() - b);
    end else begin
      checks++;
      if (done_id[b] != exp_first || done_id[b + 1] != 1) begin
        errors++;
        $display("FAIL hazard_order got %0d,%0d want %0d,1", done_id[b], done_id[b + 1], exp_first);
      end
      checks++;
      if (done_rd[b] != r0) begin
        errors++;
        $display("FAIL hazard_rd_before_ack got %0d read beats want 0", done_rd[b] - r0);
      end
      checks++;
      if (done_line[b + 1] !== exp_line(a_dc)) begin
        errors++;
        $display("FAIL hazard_line got %h want %h", done_line[b + 1], exp_line(a_dc));
      end
    end
    checks++;
    if (wr_addr_q.size() == 0 || wr_addr_q[$] !== a_sb || wr_data_q[$] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL hazard_write got %0d writes, last addr=%h data=%h want 000045/deadbeef",
               wr_addr_q.size(), (wr_addr_q.size() > 0) ? wr_addr_q[$] : 23'h0,
               (wr_data_q.size() > 0) ? wr_data_q[$] : 32'h0);
    end
  endtask

  task automatic test_stall;
    int b, r0, v0;
    logic [22:0] a;
    do_reset();
    pat_mode = 1; ready_mode = 2;
    a = 23'($urandom);
    b = done_id.size(); r0 = rd_beats; v0 = viol;
    run_req(1, a, 32'h0);
    checks++;
    if (rd_beats - r0 != 8) begin
      errors++;
      $display("FAIL stall_beats got %0d want 8", rd_beats - r0);
    end
    checks++;
    if (viol != v0) begin
      errors++;
      $display("FAIL stall_hold got %0d bus violations want 0", viol - v0);
    end
    if (done_id.size() == b + 1) begin
      // ready pattern 1,0,0: eighth beat is the 22nd read cycle
      checks++;
      if (done_cyc[b] != 24) begin
        errors++;
        $display("FAIL stall_fill_cycle got %0d want 24", done_cyc[b]);
      end
      checks++;
      if (done_line[b] !== exp_line(a)) begin
        errors++;
        $display("FAIL stall_line got %h want %h", done_line[b], exp_line(a));
      end
    end
    ready_mode = 1;
  endtask

  task automatic test_reset_midread;
    int p0, b0, b1;
    bit got = 0;
    logic [22:0] a;
    logic [255:0] l;
    do_reset();
    pat_mode = 1; ready_mode = 0;
    a = 23'($urandom);
    p0 = ic_pulses; b0 = rd_beats;
    @(negedge clk);
    ic_addr = a; ic_req = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(posedge clk); #2;
      if (rd_beats - b0 >= 4) break;
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_rd, mem_wr, sb_ack, ic_we_mem, dc_we_mem} !== 5'b0 || mem_addr !== 23'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL midrst_outputs got strobes=%b addr=%h wdata=%h want 0",
               {mem_rd, mem_wr, sb_ack, ic_we_mem, dc_we_mem}, mem_addr, mem_wdata);
    end
    checks++;
    if (line_out !== 256'h0) begin
      errors++;
      $display("FAIL midrst_line got %h want 0", line_out);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    b1 = rd_beats;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ic_we_mem) begin
        got = 1;
        l = line_out;
        break;
      end
    end
    ic_req = 1'b0;
    @(negedge clk);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL midrst_refill got no ic fill want one");
    end else begin
      checks++;
      if (l !== exp_line(a)) begin
        errors++;
        $display("FAIL midrst_line_after got %h want %h", l, exp_line(a));
      end
    end
    checks++;
    if (rd_beats - b1 != 8 || ic_pulses - p0 != 1) begin
      errors++;
      $display("FAIL midrst_counts got beats=%0d fills=%0d want 8/1", rd_beats - b1, ic_pulses - p0);
    end
  endtask

  task automatic test_round_robin;
    int b, w0, sbi, last, prev, exp;
    int cnt[3];
    logic [2:0] pend, cand;
    do_reset();
    pat_mode = 1; ready_mode = 1;
    b = done_id.size(); w0 = wr_addr_q.size();
    fork
      begin for (int i = 0; i < 4; i++) run_req(0, 23'($urandom), 32'h0); end
      begin for (int i = 0; i < 4; i++) run_req(1, {1'b0, 22'($urandom)}, 32'h0); end
      begin for (int i = 0; i < 4; i++) run_req(2, {1'b1, 22'($urandom)}, $urandom); end
    join
    checks++;
    if (done_id.size() != b + 12) begin
      errors++;
      $display("FAIL rr_count got %0d want 12", done_id.size() - b);
    end else begin
      last = 2; prev = -1; sbi = w0;
      cnt = '{0, 0, 0};
      for (int k = 0; k < 12; k++) begin
        pend = {cnt[2] < 4, cnt[1] < 4, cnt[0] < 4};
        cand = pend;
        if (prev >= 0) cand[prev] = 1'b0;
        if (cand == 3'b0) cand = pend;
        exp = rr_pick(last, cand, 1'b0);
        checks++;
        if (done_id[b + k] != exp) begin
          errors++;
          $display("FAIL rr_order idx=%0d got %0d want %0d", k, done_id[b + k], exp);
        end
        last = exp;
        prev = done_id[b + k];
        cnt[prev]++;
        if (prev != 2) begin
          checks++;
          if (done_line[b + k] !== exp_line(done_addr[b + k])) begin
            errors++;
            $display("FAIL rr_line idx=%0d got %h want %h", k, done_line[b + k], exp_line(done_addr[b + k]));
          end
        end else begin
          checks++;
          if (sbi >= wr_addr_q.size() || wr_addr_q[sbi] !== done_addr[b + k] || wr_data_q[sbi] !== done_data[b + k]) begin
            errors++;
            $display("FAIL rr_store idx=%0d want addr=%h data=%h", k, done_addr[b + k], done_data[b + k]);
          end
          sbi++;
        end
        for (int j = k - 1; j >= 0; j--) begin
          if (done_id[b + j] == done_id[b + k]) begin
            checks++;
            if (k - j - 1 > 2) begin
              errors++;
              $display("FAIL rr_wait idx=%0d got %0d others between want <=2", k, k - j - 1);
            end
            break;
          end
        end
      end
    end
  endtask

  task automatic test_invariants;
    checks++;
    if (viol != 0) begin
      errors++;
      $display("FAIL bus_invariants got %0d violations want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_single_dc();
    test_ic_dc_simultaneous();
    test_hazard();
    test_stall();
    test_reset_midread();
    test_round_robin();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
